// File: rtl/bias_bank_loader_pkg.sv
// Shared constants and FSM state type for the runtime-loadable bias bank.
package bias_bank_loader_pkg;

   localparam int unsigned BIAS_DATA_W = 8;   // signed Q1.7
   localparam int unsigned BIAS_DEPTH  = 32;  // one entry per output channel
   localparam int unsigned BIAS_ADDR_W = 16;  // engine row/col read address width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bias_bank_regs.sv
// DEPTH x DATA_W bias register file: one write port with async clear,
// one combinational read port that returns 0 outside row<DEPTH, col==0.
module bias_bank_regs
   import bias_bank_loader_pkg::*;
#(
   parameter  int unsigned DEPTH  = BIAS_DEPTH,
   parameter  int unsigned DATA_W = BIAS_DATA_W,
   parameter  int unsigned ADDR_W = BIAS_ADDR_W,
   localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] row,
   input  logic [ADDR_W-1:0] col,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] bank [DEPTH];
   logic              in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            bank[i] <= '0;
         end
      end else if (we) begin
         bank[waddr] <= wdata;
      end
   end

   // Only column 0 exists; anything else reads as zero bias.
   assign in_range = (row < ADDR_W'(DEPTH)) && (col == '0);
   assign data     = in_range ? bank[row[IDX_W-1:0]] : '0;

endmodule

// File: rtl/bias_bank_loader.sv
// Streams a Q1.7 bias vector over valid/ready into a register bank and serves
// the same combinational row/col read port as the fixed bias ROMs.
module bias_bank_loader
   import bias_bank_loader_pkg::*;
#(
   parameter  int unsigned DEPTH  = BIAS_DEPTH,
   parameter  int unsigned DATA_W = BIAS_DATA_W,
   parameter  int unsigned ADDR_W = BIAS_ADDR_W,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
   localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] row,
   input  logic [ADDR_W-1:0] col,
   output logic [DATA_W-1:0] data,
   output logic              loading,
   output logic              done,
   output logic [CNT_W-1:0]  load_count,
   output logic [DATA_W-1:0] checksum,
   output logic              err
);

   state_t state, state_nxt;
   logic   accept;
   logic   restart;
   logic   err_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      restart   = 1'b0;
      err_set   = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = LOAD;
               restart   = 1'b1;
            end
         end
         LOAD: begin
            // in_ready is high for the whole LOAD state, so accept is just in_valid.
            accept  = in_valid;
            err_set = start;
            if (accept && (load_count == CNT_W'(DEPTH - 1))) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status flags registered from the next state so they track state exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready <= 1'b0;
         loading  <= 1'b0;
         done     <= 1'b0;
      end else begin
         in_ready <= (state_nxt == LOAD);
         loading  <= (state_nxt == LOAD);
         done     <= (state_nxt == DONE);
      end
   end

   // load_count doubles as the write pointer while loading.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_count <= '0;
         checksum   <= '0;
         err        <= 1'b0;
      end else if (restart) begin
         load_count <= '0;
         checksum   <= '0;
         err        <= 1'b0;
      end else begin
         if (accept) begin
            load_count <= load_count + CNT_W'(1);
            checksum   <= checksum + in_data;
         end
         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

   bias_bank_regs #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regs (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept),
      .waddr (load_count[IDX_W-1:0]),
      .wdata (in_data),
      .row   (row),
      .col   (col),
      .data  (data)
   );

endmodule

// File: tb/tb_bias_bank_loader.sv
// Scoreboard bench for bias_bank_loader: stimulus pushes expectations, a
// negedge monitor pops and compares on read strobes and on done rising.
module tb_bias_bank_loader;

   localparam int N = 32;
   typedef int bytes_t[N];

   typedef struct {
      int cnt;
      int csum;
      int err;
   } done_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic [15:0] row = '0;
   logic [15:0] col = '0;
   logic [7:0]  data;
   logic        loading;
   logic        done;
   logic [5:0]  load_count;
   logic [7:0]  checksum;
   logic        err;

   int        vectors = 0;
   int        miscompares = 0;
   int        rd_q[$];
   done_exp_t done_q[$];
   int        model_bank[N];
   logic      rd_strobe = 1'b0;
   logic      prev_done = 1'b0;
   int        mon_e;
   done_exp_t mon_d;

   bias_bank_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .row        (row),
      .col        (col),
      .data       (data),
      .loading    (loading),
      .done       (done),
      .load_count (load_count),
      .checksum   (checksum),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compares whenever the DUT presents a read or a completed load.
   always @(negedge clk) begin
      if (rd_strobe) begin
         if (rd_q.size() == 0) begin
            check("read_unexpected", 1, 0);
         end else begin
            mon_e = rd_q.pop_front();
            check("read_data", int'($signed(data)), mon_e);
         end
      end
      if (done && !prev_done) begin
         if (done_q.size() == 0) begin
            check("done_unexpected", 1, 0);
         end else begin
            mon_d = done_q.pop_front();
            check("load_count", int'(load_count), mon_d.cnt);
            check("checksum", int'(checksum), mon_d.csum);
            check("err_at_done", int'(err), mon_d.err);
            check("ready_in_done", int'(in_ready), 0);
         end
      end
      prev_done = done;
   end

   function automatic int model_rd(input int r, input int c);
      return (r >= 0 && r < N && c == 0) ? model_bank[r] : 0;
   endfunction

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic rd(input int r, input int c);
      row = 16'(r);
      col = 16'(c);
      rd_q.push_back(model_rd(r, c));
      rd_strobe = 1'b1;
      @(posedge clk); #1;
      rd_strobe = 1'b0;
   endtask

   task automatic rd_all();
      for (int r = 0; r < N; r++) rd(r, 0);
   endtask

   task automatic load(input bytes_t b, input int gap_pct, input int start_at,
                       input int abort_after);
      int i = 0;
      int cyc = 0;
      int rdy = 0;
      int sum = 0;
      bit acc;
      bit restarted = 1'b0;
      for (int k = 0; k < N; k++) sum += b[k];
      if (abort_after < 0) begin
         done_q.push_back('{cnt: N, csum: ((sum % 256) + 256) % 256,
                            err: (start_at >= 0) ? 1 : 0});
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_loading", int'(loading), 1);
      check("start_done_clr", int'(done), 0);
      check("start_err_clr", int'(err), 0);
      check("start_count_clr", int'(load_count), 0);
      check("start_csum_clr", int'(checksum), 0);
      while (i < N && i != abort_after && cyc < 4000) begin
         in_valid = ($urandom_range(99) >= 32'(gap_pct));
         in_data  = 8'(b[i]);
         if (i == start_at && !restarted) begin
            start = 1'b1;
            restarted = 1'b1;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         if (in_ready) rdy++;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc) begin
            model_bank[i] = b[i];
            i++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      if (cyc >= 4000) check("load_timeout", i, N);
      check("ready_through_load", rdy, cyc);
      if (gap_pct == 0 && abort_after < 0) check("load_cycles", cyc, N);
      if (abort_after < 0) begin
         check("done_after_last", int'(done), 1);
         check("ready_low_after", int'(in_ready), 0);
      end
      @(posedge clk); #1;
   endtask

   bytes_t b1, b2, b3, b4;

   initial begin
      for (int k = 0; k < N; k++) b1[k] = 15;
      b1[0] = 32;  b1[1] = 2;   b1[2] = -3;  b1[3] = 12; b1[4] = 21; b1[5] = 11;
      b1[13] = 62; b1[24] = -30; b1[30] = 35; b1[31] = 25;
      for (int k = 0; k < N; k++) begin
         b2[k] = int'($urandom_range(255)) - 128;
         b3[k] = int'($urandom_range(255)) - 128;
         b4[k] = int'($urandom_range(255)) - 128;
         model_bank[k] = 0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", int'(in_ready), 0);
      check("rst_loading", int'(loading), 0);
      check("rst_done", int'(done), 0);
      check("rst_count", int'(load_count), 0);
      check("rst_csum", int'(checksum), 0);
      check("rst_err", int'(err), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rd(0, 0);

      // Full load with in_valid held high, then directed reads
      load(b1, 0, -1, -1);
      rd(13, 0);
      rd(24, 0);
      rd_all();

      // Out-of-range reads
      rd(32, 0);
      rd(5, 1);
      rd(5, 0);
      rd(16'hffff, 0);

      // Back-pressure: same stream with 50% gaps
      load(b1, 50, -1, -1);
      rd_all();

      // start mid-load at entry 10, then a clean reload from DONE
      load(b2, 0, 10, -1);
      check("err_held_done", int'(err), 1);
      load(b3, 30, -1, -1);
      rd_all();

      // Reset after 16 accepts
      load(b4, 0, -1, 16);
      check("partial_count", int'(load_count), 16);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < N; k++) model_bank[k] = 0;
      check("mid_rst_ready", int'(in_ready), 0);
      check("mid_rst_loading", int'(loading), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_count", int'(load_count), 0);
      check("mid_rst_csum", int'(checksum), 0);
      check("mid_rst_err", int'(err), 0);
      @(posedge clk); #1;
      rd(0, 0);
      rd(7, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      load(b4, 25, -1, -1);
      rd_all();

      repeat (3) @(posedge clk);
      #1;
      check("pending_reads", rd_q.size(), 0);
      check("pending_dones", done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
